card_sprite_reader: RTL and testbench

- Read-side client of the 512x3 card sprite RAM. The sprite is 16 px wide x 32 rows, and each RAM entry holds a 3-bit colour.
- Sits between the VGA timing generator (256x240 active area) and the colour DAC path.
- For each incoming pixel coordinate it:
  - hit-tests up to NUM_SLOTS card placements;
  - issues the RAM read address and RE;
  - returns the final 3-bit pixel colour after a fixed pipeline delay, with transparency and background fill applied.
- Card placements are written through a config port. They are double-buffered and take effect only at frame start, so no card tears mid-frame.

---
 rtl/card_sprite_reader.sv | 147 ++++++++++++++
 tb/tb_card_sprite_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/card_sprite_reader.sv
// card_sprite_reader
//   Read-side client of the 512x3 card sprite RAM (16 px wide x 32 rows).
//   Each incoming pixel coordinate is hit-tested against up to NUM_SLOTS card
//   placements. The RAM read is issued for the winning card, and the final
//   colour is returned two clocks later. Transparency and background fill are
//   applied to that colour.
//
// Ports
//   clock, reset_n          pixel clock, asynchronous active-low reset
//   cfg_we/cfg_slot/cfg_x/  shadow placement write port; slot indexes at or
//   cfg_y/cfg_en            above NUM_SLOTS are dropped
//   frame_start             copies shadow placements to the active set
//   px_valid/px_x/px_y      incoming pixel coordinate
//   RE/rAddr                RAM read strobe and address {row[4:0], col[3:0]}
//   dataOut                 RAM read data, one cycle after rAddr
//   pix_valid/pix_color/    output pixel, latency 2 clocks
//   pix_hit
module card_sprite_reader #(
  parameter int         NUM_SLOTS = 4,
  parameter logic [2:0] BG_COLOR  = 3'b010,
  parameter logic [2:0] TRANSP    = 3'b000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cfg_we,
  input  logic [2:0] cfg_slot,
  input  logic [7:0] cfg_x,
  input  logic [7:0] cfg_y,
  input  logic       cfg_en,
  input  logic       frame_start,
  input  logic       px_valid,
  input  logic [7:0] px_x,
  input  logic [7:0] px_y,
  output logic       RE,
  output logic [8:0] rAddr,
  input  logic [2:0] dataOut,
  output logic       pix_valid,
  output logic [2:0] pix_color,
  output logic       pix_hit
);

  logic [NUM_SLOTS-1:0] sh_en, sh_en_nxt, act_en;
  logic [7:0]           sh_x [NUM_SLOTS];
  logic [7:0]           sh_y [NUM_SLOTS];
  logic [7:0]           sh_x_nxt [NUM_SLOTS];
  logic [7:0]           sh_y_nxt [NUM_SLOTS];
  logic [7:0]           act_x [NUM_SLOTS];
  logic [7:0]           act_y [NUM_SLOTS];

  logic       any_hit;
  logic [8:0] hit_addr;
  logic [7:0] dx, dy;
  logic       s1_valid, s1_hit, s2_hit;

  // Shadow next-state. frame_start copies this next value, so a write in the
  // frame_start cycle itself lands in the active set too.
  always_comb begin
    sh_en_nxt = sh_en;
    sh_x_nxt  = sh_x;
    sh_y_nxt  = sh_y;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (cfg_we && cfg_slot == 3'(s)) begin
        sh_en_nxt[s] = cfg_en;
        sh_x_nxt[s]  = cfg_x;
        sh_y_nxt[s]  = cfg_y;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_en  <= '0;
      act_en <= '0;
      sh_x   <= '{default: '0};
      sh_y   <= '{default: '0};
      act_x  <= '{default: '0};
      act_y  <= '{default: '0};
    end else begin
      sh_en <= sh_en_nxt;
      sh_x  <= sh_x_nxt;
      sh_y  <= sh_y_nxt;
      if (frame_start) begin
        act_en <= sh_en_nxt;
        act_x  <= sh_x_nxt;
        act_y  <= sh_y_nxt;
      end
    end
  end

  // Hit test. The compares are 9 bits wide so a card near the right or bottom
  // edge clips instead of wrapping. The loop runs from the highest slot down,
  // so the lowest hitting slot is written last and wins.
  always_comb begin
    any_hit  = 1'b0;
    hit_addr = '0;
    dx       = '0;
    dy       = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (act_en[s]
          && ({1'b0, px_x} >= {1'b0, act_x[s]})
          && ({1'b0, px_x} <  ({1'b0, act_x[s]} + 9'd16))
          && ({1'b0, px_y} >= {1'b0, act_y[s]})
          && ({1'b0, px_y} <  ({1'b0, act_y[s]} + 9'd32))) begin
        any_hit  = 1'b1;
        dx       = px_x - act_x[s];
        dy       = px_y - act_y[s];
        hit_addr = {dy[4:0], dx[3:0]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      RE        <= 1'b0;
      rAddr     <= '0;
      s1_valid  <= 1'b0;
      s1_hit    <= 1'b0;
      pix_valid <= 1'b0;
      s2_hit    <= 1'b0;
    end else begin
      RE       <= px_valid & any_hit;
      if (any_hit) rAddr <= hit_addr;
      s1_valid  <= px_valid;
      s1_hit    <= px_valid & any_hit;
      pix_valid <= s1_valid;
      s2_hit    <= s1_hit;
    end
  end

  // The RAM registers its own output. dataOut is therefore already aligned
  // with the stage-2 flags, and the colour select stays combinational so the
  // total latency is two clocks. The select depends on registered flags only,
  // so reset blanks it at once.
  always_comb begin
    pix_color = 3'b000;
    pix_hit   = 1'b0;
    if (pix_valid) begin
      if (s2_hit && dataOut != TRANSP) begin
        pix_color = dataOut;
        pix_hit   = 1'b1;
      end else begin
        pix_color = BG_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_card_sprite_reader.sv
module tb_card_sprite_reader;

  localparam int NS = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_slot = '0;
  logic [7:0] cfg_x = '0;
  logic [7:0] cfg_y = '0;
  logic       cfg_en = 1'b0;
  logic       frame_start = 1'b0;
  logic       px_valid = 1'b0;
  logic [7:0] px_x = '0;
  logic [7:0] px_y = '0;
  logic       RE;
  logic [8:0] rAddr;
  logic [2:0] dataOut = '0;
  logic       pix_valid;
  logic [2:0] pix_color;
  logic       pix_hit;

  card_sprite_reader #(.NUM_SLOTS(NS), .BG_COLOR(3'b010), .TRANSP(3'b000)) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
    .frame_start(frame_start),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .RE(RE), .rAddr(rAddr), .dataOut(dataOut),
    .pix_valid(pix_valid), .pix_color(pix_color), .pix_hit(pix_hit)
  );

  always #5 clock = ~clock;

  logic [2:0] ram [512];
  always @(posedge clock) if (RE) dataOut <= ram[rAddr];

  typedef struct packed {
    logic       re;
    logic [8:0] addr;
    logic       valid;
    logic [2:0] color;
    logic       hit;
  } exp_t;

  exp_t q[$];
  bit   armed = 1'b0;
  int   total = 0;
  int   bad = 0;

  bit m_sh_en [NS];
  int m_sh_x [NS];
  int m_sh_y [NS];
  bit m_ac_en [NS];
  int m_ac_x [NS];
  int m_ac_y [NS];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input bit v, input int x, input int y);
    exp_t e;
    bit   found;
    int   a;
    e = '0;
    found = 1'b0;
    a = 0;
    for (int s = 0; s < NS; s++) begin
      if (!found && m_ac_en[s] && x >= m_ac_x[s] && x < m_ac_x[s] + 16 &&
          y >= m_ac_y[s] && y < m_ac_y[s] + 32) begin
        found = 1'b1;
        a = (y - m_ac_y[s]) * 16 + (x - m_ac_x[s]);
      end
    end
    e.re    = v && found;
    e.addr  = 9'(a);
    e.valid = v;
    if (v) begin
      if (found && ram[a] != 3'b000) begin
        e.color = ram[a];
        e.hit   = 1'b1;
      end else begin
        e.color = 3'b010;
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_sh_en[s] = 0; m_sh_x[s] = 0; m_sh_y[s] = 0;
      m_ac_en[s] = 0; m_ac_x[s] = 0; m_ac_y[s] = 0;
    end
  endtask

  task automatic cyc(input bit v, input int x, input int y, input bit we, input int slot,
                     input int cx, input int cy, input bit cen, input bit fs);
    @(negedge clock);
    px_valid = v; px_x = 8'(x); px_y = 8'(y);
    cfg_we = we; cfg_slot = 3'(slot); cfg_x = 8'(cx); cfg_y = 8'(cy); cfg_en = cen;
    frame_start = fs;
    if (armed) q.push_back(model(v, x, y));
    if (we && slot < NS) begin
      m_sh_en[slot] = cen; m_sh_x[slot] = cx; m_sh_y[slot] = cy;
    end
    if (fs) begin
      for (int s = 0; s < NS; s++) begin
        m_ac_en[s] = m_sh_en[s]; m_ac_x[s] = m_sh_x[s]; m_ac_y[s] = m_sh_y[s];
      end
    end
  endtask

  task automatic px(input bit v, input int x, input int y);
    cyc(v, x, y, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int slot, input int cx, input int cy, input bit cen, input bit fs);
    cyc(0, 0, 0, 1, slot, cx, cy, cen, fs);
  endtask

  task automatic fstart();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: one entry per clock; RE/rAddr checked one edge after issue,
  // pixel outputs checked on the following edge.
  initial begin
    exp_t cur, pend;
    bit   pend_ok;
    pend_ok = 1'b0;
    pend = '0;
    forever begin
      @(posedge clock);
      #1;
      if (!armed) begin
        pend_ok = 1'b0;
      end else begin
        if (pend_ok) begin
          chk("pix_valid", int'(pix_valid), int'(pend.valid));
          chk("pix_color", int'(pix_color), int'(pend.color));
          chk("pix_hit", int'(pix_hit), int'(pend.hit));
        end
        if (q.size() > 0) begin
          cur = q.pop_front();
          chk("RE", int'(RE), int'(cur.re));
          if (cur.re) chk("rAddr", int'(rAddr), int'(cur.addr));
          pend = cur;
          pend_ok = 1'b1;
        end else begin
          pend_ok = 1'b0;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 3'((i * 5) % 8);
    model_reset();

    #12;
    chk("rst_RE", int'(RE), 0);
    chk("rst_rAddr", int'(rAddr), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_pix_color", int'(pix_color), 0);
    chk("rst_pix_hit", int'(pix_hit), 0);
    @(negedge clock);
    reset_n = 1'b1;
    armed = 1'b1;

    // No slots enabled: background everywhere, RE never set.
    fstart();
    for (int x = 0; x < 256; x++) px((x % 7) != 3, x, 0);
    px(0, 0, 0);

    // Single card at (100,50).
    cfg(0, 100, 50, 1, 0);
    fstart();
    px(1, 100, 50);
    px(1, 115, 81);
    px(1, 116, 50);
    px(1, 99, 50);
    px(1, 100, 49);
    px(1, 100, 82);
    px(1, 107, 60);

    // Two overlapping cards: transparent texel of slot 0 shows background.
    cfg(0, 20, 20, 1, 0);
    cfg(1, 20, 20, 1, 0);
    fstart();
    px(1, 20, 20);
    px(1, 21, 20);
    px(0, 21, 20);
    px(1, 35, 51);

    // Mid-frame write is not visible until frame_start; edge clipping.
    cfg(2, 250, 230, 1, 0);
    px(1, 250, 230);
    fstart();
    px(1, 255, 239);
    px(1, 250, 230);
    px(1, 249, 230);
    px(1, 0, 230);
    px(1, 251, 229);

    // Out-of-range slot ignored; write in the frame_start cycle takes effect.
    cfg(5, 0, 0, 1, 0);
    cfg(3, 30, 100, 1, 1);
    px(1, 0, 0);
    px(1, 30, 100);
    px(1, 31, 101);

    // Full line with slot 0 covering columns 0..15.
    cfg(0, 0, 0, 1, 0);
    cfg(3, 0, 0, 0, 1);
    for (int x = 0; x < 256; x++) px(1, x, 0);

    // Reset in the middle of a covered line.
    for (int x = 0; x < 8; x++) px(1, x, 5);
    @(negedge clock);
    chk("pre_rst_pix_valid", int'(pix_valid), 1);
    #2;
    reset_n = 1'b0;
    armed = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("async_pix_valid", int'(pix_valid), 0);
    chk("async_RE", int'(RE), 0);
    chk("async_pix_hit", int'(pix_hit), 0);
    chk("async_pix_color", int'(pix_color), 0);
    chk("async_rAddr", int'(rAddr), 0);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    armed = 1'b1;
    for (int x = 0; x < 20; x++) px(1, x, 5);
    fstart();
    for (int x = 0; x < 4; x++) px(1, x, 0);
    repeat (4) px(0, 0, 0);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
